zap_intr_ctrl: RTL and testbench

ZAP_INTR_CTRL -- requirements
Module: zap_intr_ctrl

---
 rtl/zap_intr_ctrl_pkg.sv | 40 ++++
 rtl/zap_sync_2ff.sv | 31 +++
 rtl/zap_intr_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_zap_intr_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_intr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// zap_intr_ctrl_pkg
// Shared definitions for the interrupt controller:
//   - CPSR mask bit positions (I and F)
//   - configuration register addresses
//   - IRQ FSM state encoding
//   - lowest_set(): fixed-priority encoder, bit 0 highest priority
// ---------------------------------------------------------------------------
package zap_intr_ctrl_pkg;

   localparam int CPSR_I_BIT = 7;
   localparam int CPSR_F_BIT = 6;

   localparam logic [1:0] CFG_ENABLE  = 2'd0;
   localparam logic [1:0] CFG_EDGE    = 2'd1;
   localparam logic [1:0] CFG_PENDING = 2'd2;
   localparam logic [1:0] CFG_ID      = 2'd3;

   // ID register value when nothing is eligible
   localparam logic [31:0] ID_NONE = 32'h8000_0000;

   localparam int HOLD_CNT_W = 8;

   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_REQ  = 2'd1,
      IRQ_HOLD = 2'd2
   } irq_state_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [4:0] lowest_set(input logic [31:0] vec);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/zap_sync_2ff.sv
// ---------------------------------------------------------------------------
// zap_sync_2ff
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Ports:
//   i_clk    destination clock
//   i_reset  synchronous, active-high reset (clears both stages)
//   d_async  asynchronous input lines
//   q_sync   synchronized lines (two i_clk edges of latency)
// ---------------------------------------------------------------------------
module zap_sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] d_async,
   output logic [WIDTH-1:0] q_sync
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         meta   <= '0;
         q_sync <= '0;
      end else begin
         meta   <= d_async;
         q_sync <= meta;
      end
   end

endmodule

// File: rtl/zap_intr_ctrl.sv
// ---------------------------------------------------------------------------
// zap_intr_ctrl
// Interrupt controller: synchronizes IRQ/FIQ lines, keeps per-source
// ENABLE/EDGE/PENDING registers, picks the lowest-index eligible source
// and raises a registered IRQ request with a post-ack holdoff. FIQ is a
// masked, registered copy of the synchronized FIQ line with its own holdoff.
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_irq_lines, i_fiq_line  asynchronous interrupt sources
//   i_cpsr                   CPSR (I mask bit 7, F mask bit 6)
//   i_irq_ack, i_fiq_ack     single-cycle acks on exception entry
//   i_cfg_*                  config access (addr 0 ENABLE, 1 EDGE,
//                            2 PENDING (W1C on edge bits), 3 ID)
//   o_cfg_rdata              read data, one cycle after the access
//   o_irq, o_fiq, o_irq_id   registered requests and requested source ID
//
// IRQ FSM
//   state    | meaning
//   IRQ_IDLE | no request; waiting for an eligible source with I clear
//   IRQ_REQ  | source latched in o_irq_id; o_irq high after first cycle
//   IRQ_HOLD | post-ack holdoff, o_irq low for HOLDOFF cycles
// ---------------------------------------------------------------------------
module zap_intr_ctrl
   import zap_intr_ctrl_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int HOLDOFF = 2
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NUM_IRQ-1:0] i_irq_lines,
   input  logic               i_fiq_line,
   input  logic [31:0]        i_cpsr,
   input  logic               i_irq_ack,
   input  logic               i_fiq_ack,
   input  logic               i_cfg_en,
   input  logic               i_cfg_wen,
   input  logic [1:0]         i_cfg_addr,
   input  logic [31:0]        i_cfg_wdata,
   output logic [31:0]        o_cfg_rdata,
   output logic               o_irq,
   output logic               o_fiq,
   output logic [4:0]         o_irq_id
);

   localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD =
      HOLD_CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

   logic [NUM_IRQ:0]   sync_all;
   logic [NUM_IRQ-1:0] irq_sync;
   logic [NUM_IRQ-1:0] irq_dly;
   logic               fiq_sync;
   logic [NUM_IRQ-1:0] rise;

   logic [NUM_IRQ-1:0] enable;
   logic [NUM_IRQ-1:0] edge_mode;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] pending_next;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] wdata_n;
   logic [NUM_IRQ-1:0] w1c_clr;
   logic [NUM_IRQ-1:0] ack_clr;
   logic [NUM_IRQ-1:0] id_sel;
   logic               any_elig;
   logic               latched_elig;
   logic [4:0]         winner;
   logic               cfg_wr;
   logic               cfg_rd;
   logic               irq_masked;

   irq_state_t            state;
   irq_state_t            state_next;
   logic [HOLD_CNT_W-1:0] hold_cnt;
   logic [HOLD_CNT_W-1:0] hold_cnt_next;
   logic                  irq_d;
   logic                  id_load;
   logic                  ack_take;

   logic [HOLD_CNT_W-1:0] fiq_cnt;

   logic unused_inputs;
   assign unused_inputs = ^{i_cpsr, i_cfg_wdata};

   // FIQ rides in the top bit of the shared synchronizer
   zap_sync_2ff #(.WIDTH(NUM_IRQ + 1)) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .d_async ({i_fiq_line, i_irq_lines}),
      .q_sync  (sync_all)
   );

   assign irq_sync   = sync_all[NUM_IRQ-1:0];
   assign fiq_sync   = sync_all[NUM_IRQ];
   assign rise       = irq_sync & ~irq_dly;
   assign irq_masked = i_cpsr[CPSR_I_BIT];

   assign cfg_wr  = i_cfg_en & i_cfg_wen;
   assign cfg_rd  = i_cfg_en & ~i_cfg_wen;
   assign wdata_n = i_cfg_wdata[NUM_IRQ-1:0];

   assign eligible = pending & enable;
   assign any_elig = |eligible;
   assign winner   = lowest_set(32'(eligible));

   always_comb begin
      id_sel = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         id_sel[i] = (o_irq_id == 5'(i));
      end
   end

   assign latched_elig = |(eligible & id_sel);

   assign w1c_clr = (cfg_wr && i_cfg_addr == CFG_PENDING) ? (wdata_n & edge_mode) : '0;
   assign ack_clr = ack_take ? (id_sel & edge_mode) : '0;

   // A rising edge in the same cycle as a clear keeps the bit set.
   assign pending_next = (edge_mode & ((pending & ~(w1c_clr | ack_clr)) | rise))
                       | (~edge_mode & irq_sync);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         irq_dly   <= '0;
         enable    <= '0;
         edge_mode <= '0;
         pending   <= '0;
      end else begin
         irq_dly <= irq_sync;
         pending <= pending_next;
         if (cfg_wr && i_cfg_addr == CFG_ENABLE) enable    <= wdata_n;
         if (cfg_wr && i_cfg_addr == CFG_EDGE)   edge_mode <= wdata_n;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_cfg_rdata <= '0;
      end else if (cfg_rd) begin
         case (i_cfg_addr)
            CFG_ENABLE:  o_cfg_rdata <= 32'(enable);
            CFG_EDGE:    o_cfg_rdata <= 32'(edge_mode);
            CFG_PENDING: o_cfg_rdata <= 32'(pending);
            default:     o_cfg_rdata <= any_elig ? 32'(winner) : ID_NONE;
         endcase
      end
   end

   // FSM: state register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= IRQ_IDLE;
         hold_cnt <= '0;
         o_irq    <= 1'b0;
         o_irq_id <= '0;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_cnt_next;
         o_irq    <= irq_d;
         if (id_load) o_irq_id <= winner;
      end
   end

   // FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         IRQ_IDLE: if (any_elig && !irq_masked) state_next = IRQ_REQ;
         IRQ_REQ: begin
            if (i_irq_ack)                         state_next = IRQ_HOLD;
            else if (irq_masked || !latched_elig)  state_next = IRQ_IDLE;
         end
         IRQ_HOLD: if (hold_cnt == '0) state_next = IRQ_IDLE;
         default:  state_next = IRQ_IDLE;
      endcase
   end

   // FSM: outputs. o_irq is only raised once REQ has persisted a cycle.
   always_comb begin
      irq_d         = 1'b0;
      id_load       = 1'b0;
      ack_take      = 1'b0;
      hold_cnt_next = hold_cnt;
      case (state)
         IRQ_IDLE: id_load = (state_next == IRQ_REQ);
         IRQ_REQ: begin
            ack_take = i_irq_ack;
            irq_d    = (state_next == IRQ_REQ);
            if (state_next == IRQ_HOLD) hold_cnt_next = HOLD_LOAD;
         end
         IRQ_HOLD: if (hold_cnt != '0) hold_cnt_next = hold_cnt - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         fiq_cnt <= '0;
         o_fiq   <= 1'b0;
      end else begin
         if (i_fiq_ack)           fiq_cnt <= HOLD_LOAD;
         else if (fiq_cnt != '0)  fiq_cnt <= fiq_cnt - 1'b1;
         o_fiq <= fiq_sync & ~i_cpsr[CPSR_F_BIT] & ~i_fiq_ack & (fiq_cnt == '0);
      end
   end

endmodule

// File: tb/tb_zap_intr_ctrl.sv
module tb_zap_intr_ctrl;
   import zap_intr_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  irq_lines = '0;
   logic        fiq_line = 1'b0;
   logic [31:0] cpsr = '0;
   logic        irq_ack = 1'b0;
   logic        fiq_ack = 1'b0;
   logic        cfg_en = 1'b0;
   logic        cfg_wen = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic [31:0] cfg_rdata;
   logic        irq;
   logic        fiq;
   logic [4:0]  irq_id;

   int total = 0;
   int bad = 0;

   zap_intr_ctrl #(.NUM_IRQ(8), .HOLDOFF(2)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_irq_lines (irq_lines),
      .i_fiq_line  (fiq_line),
      .i_cpsr      (cpsr),
      .i_irq_ack   (irq_ack),
      .i_fiq_ack   (fiq_ack),
      .i_cfg_en    (cfg_en),
      .i_cfg_wen   (cfg_wen),
      .i_cfg_addr  (cfg_addr),
      .i_cfg_wdata (cfg_wdata),
      .o_cfg_rdata (cfg_rdata),
      .o_irq       (irq),
      .o_fiq       (fiq),
      .o_irq_id    (irq_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_en = 1'b1; cfg_wen = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_en = 1'b0; cfg_wen = 1'b0; cfg_wdata = '0;
   endtask

   task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
      cfg_en = 1'b1; cfg_wen = 1'b0; cfg_addr = a;
      tick();
      cfg_en = 1'b0;
      d = cfg_rdata;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0h exp=0", irq); end
      total++; if (fiq !== 1'b0) begin bad++; $display("FAIL reset_fiq got=%0h exp=0", fiq); end
      total++; if (irq_id !== 5'd0) begin bad++; $display("FAIL reset_id got=%0h exp=0", irq_id); end
      total++; if (cfg_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", cfg_rdata); end
      cfg_read(CFG_ENABLE, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_enable got=%0h exp=0", rd); end
      cfg_read(CFG_EDGE, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_edge got=%0h exp=0", rd); end
      cfg_read(CFG_PENDING, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_pending got=%0h exp=0", rd); end
      cfg_read(CFG_ID, rd);
      total++; if (rd !== 32'h8000_0000) begin bad++; $display("FAIL reset_id_none got=%0h exp=80000000", rd); end
   endtask

   task automatic test_edge_irq();
      logic [31:0] rd;
      cpsr = '0;
      cfg_write(CFG_ENABLE, 32'h01);
      cfg_write(CFG_EDGE, 32'h01);
      irq_lines[0] = 1'b1;
      tick();                         // edge k
      irq_lines[0] = 1'b0;
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_lat_k got=%0h exp=0", irq); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_lat_k%0d got=%0h exp=0", i, irq); end
      end
      tick();                         // edge k+4
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL edge_lat_k4 got=%0h exp=1", irq); end
      total++; if (irq_id !== 5'd0) begin bad++; $display("FAIL edge_id got=%0h exp=0", irq_id); end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_ack_low1 got=%0h exp=0", irq); end
      tick();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_ack_low2 got=%0h exp=0", irq); end
      cfg_read(CFG_PENDING, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL edge_ack_pending got=%0h exp=0", rd); end
      tick(); tick(); tick();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_no_rearm got=%0h exp=0", irq); end
      cfg_write(CFG_ENABLE, 32'h0);
      cfg_write(CFG_EDGE, 32'h0);
   endtask

   task automatic test_level_priority();
      irq_lines[3] = 1'b1;
      irq_lines[5] = 1'b1;
      tick(); tick(); tick(); tick();
      cfg_write(CFG_ENABLE, 32'h28);  // edge e
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_e got=%0h exp=0", irq); end
      tick();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_e1 got=%0h exp=0", irq); end
      tick();
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL lvl_e2 got=%0h exp=1", irq); end
      total++; if (irq_id !== 5'd3) begin bad++; $display("FAIL lvl_id3 got=%0d exp=3", irq_id); end
      irq_ack = 1'b1;
      irq_lines[3] = 1'b0;
      tick();                         // edge a
      irq_ack = 1'b0;
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_hold_a got=%0h exp=0", irq); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_hold_a%0d got=%0h exp=0", i, irq); end
      end
      tick();                         // edge a+4
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL lvl_rearm got=%0h exp=1", irq); end
      total++; if (irq_id !== 5'd5) begin bad++; $display("FAIL lvl_id5 got=%0d exp=5", irq_id); end
      irq_lines[5] = 1'b0;
      for (int i = 0; i <= 2; i++) begin
         tick();
         total++; if (irq !== 1'b1) begin bad++; $display("FAIL lvl_drop_b%0d got=%0h exp=1", i, irq); end
      end
      tick();                         // edge b+3
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_drop_idle got=%0h exp=0", irq); end
      cfg_write(CFG_ENABLE, 32'h0);
   endtask

   task automatic test_mask();
      logic [31:0] rd;
      cpsr = 32'h80;
      cfg_write(CFG_EDGE, 32'h04);
      cfg_write(CFG_ENABLE, 32'h04);
      irq_lines[2] = 1'b1;
      tick();
      irq_lines[2] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_%0d got=%0h exp=0", i, irq); end
      end
      cfg_read(CFG_PENDING, rd);
      total++; if (rd !== 32'h04) begin bad++; $display("FAIL mask_pending got=%0h exp=4", rd); end
      cpsr = 32'h0;
      tick();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_unmask_j got=%0h exp=0", irq); end
      tick();
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_unmask_j1 got=%0h exp=1", irq); end
      total++; if (irq_id !== 5'd2) begin bad++; $display("FAIL mask_id got=%0d exp=2", irq_id); end
      cpsr = 32'h80;
      tick();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_remask got=%0h exp=0", irq); end
      cfg_read(CFG_PENDING, rd);
      total++; if (rd !== 32'h04) begin bad++; $display("FAIL mask_pending_kept got=%0h exp=4", rd); end
      cpsr = 32'h0;
      tick(); tick();
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_rereq got=%0h exp=1", irq); end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_ack got=%0h exp=0", irq); end
      cfg_read(CFG_PENDING, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL mask_ack_clear got=%0h exp=0", rd); end
      tick(); tick(); tick();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_quiet got=%0h exp=0", irq); end
      cfg_write(CFG_ENABLE, 32'h0);
      cfg_write(CFG_EDGE, 32'h0);
   endtask

   task automatic test_w1c_race();
      logic [31:0] rd;
      cpsr = 32'h80;
      cfg_write(CFG_EDGE, 32'h02);
      cfg_write(CFG_ENABLE, 32'h02);
      irq_lines[1] = 1'b1;
      tick();
      irq_lines[1] = 1'b0;
      tick(); tick(); tick();
      cfg_read(CFG_PENDING, rd);
      total++; if (rd !== 32'h02) begin bad++; $display("FAIL race_pre_pending got=%0h exp=2", rd); end
      cfg_read(CFG_ID, rd);
      total++; if (rd !== 32'h01) begin bad++; $display("FAIL race_id got=%0h exp=1", rd); end
      irq_lines[1] = 1'b1;
      tick();                         // edge m
      irq_lines[1] = 1'b0;
      tick();                         // edge m+1
      cfg_write(CFG_PENDING, 32'h02); // edge m+2, coincides with the rise
      cfg_read(CFG_PENDING, rd);
      total++; if (rd !== 32'h02) begin bad++; $display("FAIL race_set_wins got=%0h exp=2", rd); end
      cfg_write(CFG_PENDING, 32'h02);
      cfg_read(CFG_PENDING, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL race_w1c got=%0h exp=0", rd); end
      cfg_read(CFG_ID, rd);
      total++; if (rd !== 32'h8000_0000) begin bad++; $display("FAIL race_id_none got=%0h exp=80000000", rd); end
      cfg_write(CFG_ENABLE, 32'hFFFF_FFFF);
      cfg_read(CFG_ENABLE, rd);
      total++; if (rd !== 32'h0000_00FF) begin bad++; $display("FAIL enable_width got=%0h exp=ff", rd); end
      cfg_write(CFG_ENABLE, 32'h0);
      cfg_write(CFG_EDGE, 32'h0);
      cpsr = 32'h0;
   endtask

   task automatic test_fiq();
      cpsr = 32'h0;
      fiq_line = 1'b1;
      tick();
      total++; if (fiq !== 1'b0) begin bad++; $display("FAIL fiq_k got=%0h exp=0", fiq); end
      tick();
      total++; if (fiq !== 1'b0) begin bad++; $display("FAIL fiq_k1 got=%0h exp=0", fiq); end
      tick();
      total++; if (fiq !== 1'b1) begin bad++; $display("FAIL fiq_k2 got=%0h exp=1", fiq); end
      fiq_ack = 1'b1;
      tick();
      fiq_ack = 1'b0;
      total++; if (fiq !== 1'b0) begin bad++; $display("FAIL fiq_hold1 got=%0h exp=0", fiq); end
      tick();
      total++; if (fiq !== 1'b0) begin bad++; $display("FAIL fiq_hold2 got=%0h exp=0", fiq); end
      tick();
      total++; if (fiq !== 1'b1) begin bad++; $display("FAIL fiq_release got=%0h exp=1", fiq); end
      cpsr = 32'h40;
      tick();
      total++; if (fiq !== 1'b0) begin bad++; $display("FAIL fiq_fmask got=%0h exp=0", fiq); end
      cpsr = 32'h0;
      tick();
      total++; if (fiq !== 1'b1) begin bad++; $display("FAIL fiq_unmask got=%0h exp=1", fiq); end
      fiq_line = 1'b0;
      tick(); tick(); tick();
      total++; if (fiq !== 1'b0) begin bad++; $display("FAIL fiq_drop got=%0h exp=0", fiq); end
   endtask

   task automatic test_reset_mid_req();
      logic [31:0] rd;
      int waited;
      cpsr = 32'h0;
      cfg_write(CFG_ENABLE, 32'h04);
      irq_lines[2] = 1'b1;
      waited = 0;
      while (irq !== 1'b1 && waited < 12) begin
         tick();
         waited++;
      end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL rst_wait_irq got=%0h exp=1 (timeout)", irq); end
      total++; if (irq_id !== 5'd2) begin bad++; $display("FAIL rst_pre_id got=%0d exp=2", irq_id); end
      cfg_read(CFG_ENABLE, rd);
      total++; if (rd !== 32'h04) begin bad++; $display("FAIL rst_pre_enable got=%0h exp=4", rd); end
      reset = 1'b1;
      irq_lines[2] = 1'b0;
      tick();
      reset = 1'b0;
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%0h exp=0", irq); end
      total++; if (irq_id !== 5'd0) begin bad++; $display("FAIL rst_id got=%0d exp=0", irq_id); end
      total++; if (cfg_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", cfg_rdata); end
      cfg_read(CFG_ENABLE, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_enable got=%0h exp=0", rd); end
      cfg_read(CFG_EDGE, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_edge got=%0h exp=0", rd); end
      cfg_read(CFG_PENDING, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_pending got=%0h exp=0", rd); end
      tick(); tick(); tick();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_quiet got=%0h exp=0", irq); end
   endtask

   initial begin
      test_reset();
      test_edge_irq();
      test_level_priority();
      test_mask();
      test_w1c_race();
      test_fiq();
      test_reset_mid_req();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
